// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states, reset PC default and the IF/ID bundle.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        HOLD,
        DROP
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic        valid;
        logic [31:0] inst;
        logic [31:0] pc;
    } ifid_t;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & ~32'h3;
    endfunction

endpackage

// File: rtl/if_perf_counters.sv
// Free-running fetch/stall event counters for the IF stage; both wrap at 2^32.
module if_perf_counters (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_inc,
    input  logic        stall_inc,
    output logic [31:0] fetch_cnt,
    output logic [31:0] stall_cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (fetch_inc) fetch_cnt <= fetch_cnt + 32'd1;
            if (stall_inc) stall_cnt <= stall_cnt + 32'd1;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, imem req/ack handshake and IF/ID register.
// Define IF_PERF_CNT_EN to add the fetch_cnt/stall_cnt performance counters.
module if_fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] npc,
    input  logic        redirect,
    input  logic        loaddepend,
    output logic [31:0] pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] fetch_cnt,
    output logic [31:0] stall_cnt
`endif
);

    fetch_state_e state, state_n;
    ifid_t        ifid, ifid_n;
    logic [31:0]  pc_n;
    logic [31:0]  buf_inst, buf_inst_n, buf_pc, buf_pc_n;
    logic [31:0]  drop_addr, drop_addr_n;

    // A redirected-away fetch keeps its original address on the bus until acked.
    assign imem_req  = (state == REQ) || (state == DROP);
    assign imem_addr = (state == DROP) ? drop_addr : pc;
    assign id_valid  = ifid.valid;
    assign id_inst   = ifid.inst;
    assign id_pc     = ifid.pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            ifid      <= '0;
            buf_inst  <= '0;
            buf_pc    <= '0;
            drop_addr <= '0;
        end else begin
            state     <= state_n;
            pc        <= pc_n;
            ifid      <= ifid_n;
            buf_inst  <= buf_inst_n;
            buf_pc    <= buf_pc_n;
            drop_addr <= drop_addr_n;
        end
    end

    always_comb begin
        state_n     = state;
        pc_n        = pc;
        ifid_n      = ifid;
        buf_inst_n  = buf_inst;
        buf_pc_n    = buf_pc;
        drop_addr_n = drop_addr;
        if (redirect) begin
            // Redirect beats stall; leaving HOLD implicitly discards the buffer.
            ifid_n.valid = 1'b0;
            pc_n         = word_align(npc);
            if ((state == REQ || state == DROP) && !imem_ack) begin
                state_n = DROP;
                if (state == REQ) drop_addr_n = pc;
            end else begin
                state_n = REQ;
            end
        end else begin
            case (state)
                IDLE: state_n = REQ;
                REQ: begin
                    if (imem_ack) begin
                        if (!loaddepend) begin
                            ifid_n = '{valid: 1'b1, inst: imem_rdata, pc: pc};
                            pc_n   = word_align(npc);
                        end else begin
                            buf_inst_n = imem_rdata;
                            buf_pc_n   = pc;
                            state_n    = HOLD;
                        end
                    end else if (!loaddepend) begin
                        ifid_n.valid = 1'b0;
                    end
                end
                HOLD: begin
                    if (!loaddepend) begin
                        ifid_n  = '{valid: 1'b1, inst: buf_inst, pc: buf_pc};
                        pc_n    = word_align(npc);
                        state_n = REQ;
                    end
                end
                DROP: begin
                    if (imem_ack) state_n = REQ;
                end
            endcase
        end
    end

`ifdef IF_PERF_CNT_EN
    logic fetch_inc, stall_inc;

    assign fetch_inc = !redirect && !loaddepend &&
                       (((state == REQ) && imem_ack) || (state == HOLD));
    assign stall_inc = (state == HOLD) || ((state == REQ) && !imem_ack);

    if_perf_counters u_perf (
        .clk       (clk),
        .rst_n     (rst_n),
        .fetch_inc (fetch_inc),
        .stall_inc (stall_inc),
        .fetch_cnt (fetch_cnt),
        .stall_cnt (stall_cnt)
    );
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed vector table, random run against an
// in-order instruction-stream model, and an asynchronous mid-handshake reset.
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ld, ack, rd;
    logic [31:0] tgt, npc, pc, imem_addr, imem_rdata, id_inst, id_pc;
    logic        imem_req, id_valid;
`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt, stall_cnt;
`endif

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a * 32'h9E37_79B1 + 32'h1234_5678;
    endfunction

    // Bench plays next-PC logic and a memory returning the addressed word.
    assign npc        = rd ? tgt : pc + 32'd4;
    assign imem_rdata = inst_of(imem_addr);

    if_fetch_stage #(.RESET_PC(32'h100)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .npc        (npc),
        .redirect   (rd),
        .loaddepend (ld),
        .pc         (pc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (ack),
        .imem_rdata (imem_rdata),
        .id_valid   (id_valid),
        .id_inst    (id_inst),
        .id_pc      (id_pc)
`ifdef IF_PERF_CNT_EN
        ,
        .fetch_cnt  (fetch_cnt),
        .stall_cnt  (stall_cnt)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        req;
        logic [31:0] addr;
        logic        v;
        logic [31:0] idpc;
        logic        ci;
        logic        ld;
        logic        ack;
        logic        rd;
        logic [31:0] tgt;
    } vec_t;

    vec_t tbl [0:26];

    task automatic do_reset();
        rst_n = 1'b0;
        ld = 1'b0; ack = 1'b0; rd = 1'b0; tgt = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc", pc, 32'h100);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, 32'h100);
        chk("rst_valid", {31'd0, id_valid}, 32'd0);
        chk("rst_inst", id_inst, 32'd0);
        chk("rst_idpc", id_pc, 32'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] exp_pc, p_addr;
        logic        p_req, p_ack;
        int          consumed;

        // Observed outputs at the start of a cycle, then inputs for that cycle.
        tbl[0]  = '{0, 32'h100, 0, 32'h0, 0, 0, 0, 0, 32'h0};
        tbl[1]  = '{1, 32'h100, 0, 32'h0, 0, 0, 1, 0, 32'h0};
        tbl[2]  = '{1, 32'h104, 1, 32'h100, 1, 0, 1, 0, 32'h0};
        tbl[3]  = '{1, 32'h108, 1, 32'h104, 1, 0, 0, 0, 32'h0};
        tbl[4]  = '{1, 32'h108, 0, 32'h104, 1, 0, 0, 0, 32'h0};
        tbl[5]  = '{1, 32'h108, 0, 32'h104, 1, 0, 0, 0, 32'h0};
        tbl[6]  = '{1, 32'h108, 0, 32'h104, 1, 0, 1, 0, 32'h0};
        tbl[7]  = '{1, 32'h10C, 1, 32'h108, 1, 1, 1, 0, 32'h0};
        tbl[8]  = '{0, 32'h10C, 1, 32'h108, 1, 1, 0, 0, 32'h0};
        tbl[9]  = '{0, 32'h10C, 1, 32'h108, 1, 0, 0, 0, 32'h0};
        tbl[10] = '{1, 32'h110, 1, 32'h10C, 1, 0, 0, 0, 32'h0};
        tbl[11] = '{1, 32'h110, 0, 32'h10C, 1, 0, 0, 1, 32'h2000};
        tbl[12] = '{1, 32'h110, 0, 32'h10C, 1, 0, 1, 0, 32'h0};
        tbl[13] = '{1, 32'h2000, 0, 32'h10C, 1, 0, 1, 0, 32'h0};
        tbl[14] = '{1, 32'h2004, 1, 32'h2000, 1, 1, 1, 0, 32'h0};
        tbl[15] = '{0, 32'h2004, 1, 32'h2000, 1, 1, 0, 1, 32'h3000};
        tbl[16] = '{1, 32'h3000, 0, 32'h2000, 1, 0, 1, 0, 32'h0};
        tbl[17] = '{1, 32'h3004, 1, 32'h3000, 1, 0, 1, 1, 32'h40};
        tbl[18] = '{1, 32'h40, 0, 32'h3000, 1, 1, 0, 0, 32'h0};
        tbl[19] = '{1, 32'h40, 0, 32'h3000, 1, 0, 1, 0, 32'h0};
        tbl[20] = '{1, 32'h44, 1, 32'h40, 1, 0, 0, 1, 32'h8000};
        tbl[21] = '{1, 32'h44, 0, 32'h40, 1, 0, 0, 1, 32'h500};
        tbl[22] = '{1, 32'h44, 0, 32'h40, 1, 0, 1, 0, 32'h0};
        tbl[23] = '{1, 32'h500, 0, 32'h40, 1, 0, 1, 1, 32'hFFFF_FFFF};
        tbl[24] = '{1, 32'hFFFF_FFFC, 0, 32'h40, 1, 0, 1, 0, 32'h0};
        tbl[25] = '{1, 32'h0, 1, 32'hFFFF_FFFC, 1, 0, 0, 0, 32'h0};
        tbl[26] = '{1, 32'h0, 0, 32'hFFFF_FFFC, 1, 0, 0, 0, 32'h0};

        do_reset();
        for (int i = 0; i <= 26; i++) begin
            chk($sformatf("v%0d_req", i), {31'd0, imem_req}, {31'd0, tbl[i].req});
            chk($sformatf("v%0d_addr", i), imem_addr, tbl[i].addr);
            chk($sformatf("v%0d_valid", i), {31'd0, id_valid}, {31'd0, tbl[i].v});
            chk($sformatf("v%0d_idpc", i), id_pc, tbl[i].idpc);
            if (tbl[i].ci) chk($sformatf("v%0d_inst", i), id_inst, inst_of(tbl[i].idpc));
`ifdef IF_PERF_CNT_EN
            if (i == 26) begin
                chk("perf_fetch", fetch_cnt, 32'd8);
                chk("perf_stall", stall_cnt, 32'd11);
            end
`endif
            ld = tbl[i].ld; ack = tbl[i].ack; rd = tbl[i].rd; tgt = tbl[i].tgt;
            @(posedge clk);
            #1;
        end

        // Random run: every word decode consumes must be the next one in program order.
        do_reset();
        exp_pc = 32'h100; consumed = 0; p_req = 1'b0; p_ack = 1'b0; p_addr = '0;
        for (int c = 0; c < 2000; c++) begin
            if (p_req && !p_ack) begin
                chk("hs_req_held", {31'd0, imem_req}, 32'd1);
                chk("hs_addr_held", imem_addr, p_addr);
            end
            ld  = ($urandom_range(0, 3) == 0);
            rd  = ($urandom_range(0, 19) == 0);
            tgt = $urandom & 32'h0000_3FFF;
            ack = imem_req && ($urandom_range(0, 3) != 0);
            #1;
            if (id_valid && !ld) begin
                chk("rnd_pc", id_pc, exp_pc);
                chk("rnd_inst", id_inst, inst_of(exp_pc));
                consumed++;
                exp_pc = exp_pc + 32'd4;
            end
            if (rd) exp_pc = tgt & ~32'h3;
            p_req = imem_req; p_ack = ack; p_addr = imem_addr;
            @(posedge clk);
            #1;
        end
        chk("rnd_liveness", {31'd0, consumed >= 300}, 32'd1);

        // Asynchronous reset while a request is outstanding.
        ld = 1'b0; ack = 1'b0; rd = 1'b0;
        for (int i = 0; i < 10 && !imem_req; i++) begin
            @(posedge clk);
            #1;
        end
        chk("mid_req_seen", {31'd0, imem_req}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_req", {31'd0, imem_req}, 32'd0);
        chk("mid_rst_addr", imem_addr, 32'h100);
        chk("mid_rst_valid", {31'd0, id_valid}, 32'd0);
        chk("mid_rst_idpc", id_pc, 32'd0);
        chk("mid_rst_inst", id_inst, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        chk("post_rst_idle", {31'd0, imem_req}, 32'd0);
        @(posedge clk);
        #1;
        chk("post_rst_req", {31'd0, imem_req}, 32'd1);
        chk("post_rst_addr", imem_addr, 32'h100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
